period_capture: RTL
===================

Name: period_capture

Overview:
- Measures the interval, in clk cycles, between consecutive rising edges of a synchronous pulse/level input.
- Counterpart to the team's auto-reload timer: the timer generates periodic done pulses, and this block measures them, for example to check timer tick periods or to capture external event rates.
- Each measurement is delivered through a valid/ready output register, with saturation and overrun reporting.

Parameters:
- WIDTH, 16, width of the cycle counter and captured period; MAX = 2^WIDTH-1.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- enable  in  1  measurement enable; low forces IDLE.
- event_in  in  1  synchronous input; rising edge = event.
- period  out  WIDTH  captured interval in cycles.
- period_ovf  out  1  qualifies period: interval exceeded MAX.
- period_valid  out  1  period/period_ovf hold a capture not yet consumed.
- period_ready  in  1  consumer accepts on period_valid && period_ready.
- overrun  out  1  sticky: a capture overwrote an unconsumed one.
- clear_overrun  in  1  clears overrun.

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, cnt=0, prev_event=0.
  - period=0, period_ovf=0, period_valid=0, overrun=0.
- Edge detect:
  - prev_event registers event_in every cycle, including in IDLE and while enable is low; reset value 0.
  - edge = event_in && !prev_event, evaluated combinationally from current samples.
- States:
  - IDLE: cnt held at 0.
    - enable && edge -> MEASURE with cnt<=0. No capture is produced; this edge is the reference edge.
  - MEASURE, enable low: -> IDLE, cnt<=0, no capture. Takes priority over edge in the same cycle.
  - MEASURE, enable high, edge: capture, cnt<=0, stay in MEASURE.
  - MEASURE, enable high, no edge: cnt<=cnt+1, saturating at MAX.
- Capture values:
  - period <= (cnt==MAX) ? MAX : cnt+1.
  - period_ovf <= (cnt==MAX).
- Result: rising edges detected at posedges t and t+N give period=N.
  - N=MAX gives period=MAX, ovf=0.
  - Any N>MAX gives period=MAX, ovf=1.
  - Minimum N is 2, because the input must be low between edges.
- Latency: period_valid is visible in the cycle after the posedge that sampled the second edge.
- Output handshake (evaluated each posedge):
  - capture && (!period_valid || period_ready): load period/period_ovf, period_valid<=1, overrun unchanged.
  - capture && period_valid && !period_ready: overwrite period/period_ovf, period_valid stays 1, overrun<=1.
  - No capture && period_valid && period_ready: period_valid<=0. period/period_ovf hold their last values.
- overrun:
  - clear_overrun in a cycle with no overrun-setting event: overrun<=0.
  - Set and clear in the same cycle: set wins.
- period/period_ovf are stable while period_valid=1 && !period_ready, unless overwritten as above.
- Dropping enable does not clear period_valid; a pending capture remains available.
- rst mid-measurement: everything returns to reset values next cycle. The pending capture is lost, and the first edge after reset is again a reference edge.
- cnt is never observable directly and never wraps.

Test Plan:
- WIDTH=16, enable=1, period_ready=1; 1-cycle pulses on event_in every 10 cycles -> first pulse gives no capture; each later pulse gives period=10, period_ovf=0, period_valid high for exactly 1 cycle, one cycle after the pulse.
- Pulses 4 then 7 cycles apart with period_ready=0 -> period_valid stays 1; period becomes 4, then is overwritten to 7 with overrun=1. Raise period_ready -> 7 is consumed and period_valid=0. Pulse clear_overrun -> overrun=0.
- WIDTH=8, edges 255 apart -> period=255, ovf=0. Edges 300 apart -> period=255, ovf=1.
- Square wave high 3/low 3 (edges 6 apart), enable dropped for 1 cycle mid-interval -> no capture for that interval; the next edge is a reference only; the following edge gives period=6.
- period_ready=1 asserted in the same cycle a new capture loads while period_valid=1 -> old value consumed, new value valid next cycle, overrun stays 0. Assert rst during MEASURE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/period_capture.sv
// period_capture: measures the number of clk cycles between consecutive rising
// edges of event_in and presents each measurement through a valid/ready output
// register, with saturation (period_ovf) and sticky overrun reporting.
module period_capture #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             event_in,
    output logic [WIDTH-1:0] period,
    output logic             period_ovf,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overrun,
    input  logic             clear_overrun
);

    // state   | meaning
    // IDLE    | waiting for the reference edge; cnt held at 0
    // MEASURE | reference seen; cnt counts cycles since the last edge
    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [WIDTH-1:0] MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             prev_event;
    logic             event_edge;
    logic             capture;
    logic [WIDTH-1:0] cap_period;
    logic             cap_ovf;
    logic             overrun_set;

    assign event_edge  = event_in && !prev_event;
    // cnt sticks at MAX, so a saturated count means the interval exceeded MAX
    assign cap_period  = (cnt == MAX) ? MAX : cnt + 1'b1;
    assign cap_ovf     = (cnt == MAX);
    assign overrun_set = capture && period_valid && !period_ready;

    // State, counter and edge-detect history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            prev_event <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            prev_event <= event_in;
        end
    end

    // Next-state and counter logic; enable low overrides an edge in MEASURE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (enable && event_edge) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (event_edge) begin
                    capture = 1'b1;
                    cnt_nxt = '0;
                end else if (cnt != MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output register with valid/ready handshake and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            period       <= '0;
            period_ovf   <= 1'b0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (capture) begin
                period       <= cap_period;
                period_ovf   <= cap_ovf;
                period_valid <= 1'b1;
            end else if (period_valid && period_ready) begin
                period_valid <= 1'b0;
            end

            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
